// File: rtl/serial_operand_feeder_pkg.sv
// Shared types for the serial operand feeder.
// State encoding is kept as plain 2-bit constants.
package serial_operand_feeder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t CLEAR   = 2'd1;
  localparam state_t SHIFT   = 2'd2;
  localparam state_t CAPTURE = 2'd3;

endpackage

// File: rtl/serial_operand_feeder_if.sv
// Operand handshake, serial comparator link and result bundle.
// master = operand source + comparator, slave = feeder.
interface serial_operand_feeder_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cmp_reset;
  logic             a_bit;
  logic             b_bit;
  logic             bit_valid;
  logic             g_in;
  logic             e_in;
  logic             l_in;
  logic             gt;
  logic             eq;
  logic             lt;
  logic             done;

  modport master (
    output start, a_in, b_in,
    output g_in, e_in, l_in,
    input  ready, cmp_reset,
    input  a_bit, b_bit, bit_valid,
    input  gt, eq, lt, done
  );

  modport slave (
    input  start, a_in, b_in,
    input  g_in, e_in, l_in,
    output ready, cmp_reset,
    output a_bit, b_bit, bit_valid,
    output gt, eq, lt, done
  );

endinterface

// File: rtl/serial_operand_feeder.sv
// Feeds two parallel operands MSB-first into a bit-serial
// comparator and captures its one-hot verdict.
module serial_operand_feeder
  import serial_operand_feeder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                   clk,
  input logic                   reset,
  serial_operand_feeder_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CW-1:0]    cnt;
  logic             gt_q;
  logic             eq_q;
  logic             lt_q;
  logic             done_q;
  logic             shifting;

  assign shifting      = (state == SHIFT);
  assign bus.ready     = (state == IDLE);
  assign bus.cmp_reset = reset | (state == CLEAR);
  assign bus.bit_valid = shifting;
  // Equal pair outside SHIFT keeps the comparator state intact
  assign bus.a_bit     = shifting & a_sh[WIDTH-1];
  assign bus.b_bit     = shifting & b_sh[WIDTH-1];
  assign bus.gt        = gt_q;
  assign bus.eq        = eq_q;
  assign bus.lt        = lt_q;
  assign bus.done      = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      cnt    <= '0;
      gt_q   <= 1'b0;
      eq_q   <= 1'b0;
      lt_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh  <= bus.a_in;
            b_sh  <= bus.b_in;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          cnt   <= CW'(WIDTH - 1);
          state <= SHIFT;
        end
        SHIFT: begin
          a_sh <= a_sh << 1;
          b_sh <= b_sh << 1;
          if (cnt == '0) begin
            state <= CAPTURE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        CAPTURE: begin
          gt_q   <= bus.g_in;
          eq_q   <= bus.e_in;
          lt_q   <= bus.l_in;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_operand_feeder.md
Name: serial_operand_feeder

Overview:
- Upstream stage for the bit-serial MSB-first magnitude comparator.
- Accepts two WIDTH-bit operands in parallel through a start/ready handshake.
- Drives the comparator's serial reset and bit-pair inputs, then captures the comparator's one-hot greater/equal/less verdict into held result registers with a one-cycle done pulse.
- Sits between the parallel operand source and the serial comparator; the comparator updates on the rising clk edge.

Parameters:
WIDTH, 8, operand width in bits; legal range >= 1.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  request to compare a_in/b_in; accepted only when ready=1.
a_in  in  WIDTH  operand A, sampled on the accept edge.
b_in  in  WIDTH  operand B, sampled on the accept edge.
ready  out  1  high in IDLE; combinational from state.
cmp_reset  out  1  reset to comparator; high in CLEAR or while reset=1.
a_bit  out  1  serial bit of A, MSB first.
b_bit  out  1  serial bit of B, MSB first.
bit_valid  out  1  high while a_bit/b_bit carry operand bits (SHIFT).
g_in  in  1  comparator greater output.
e_in  in  1  comparator equal output.
l_in  in  1  comparator less output.
gt  out  1  held result: A > B.
eq  out  1  held result: A == B.
lt  out  1  held result: A < B.
done  out  1  one-cycle pulse; new result valid in gt/eq/lt.

Behaviour:
- Reset is synchronous and active-high; clk and reset are the only clock/reset.
- Reset values: state=IDLE, ready=1, bit_valid=0, a_bit=b_bit=0, done=0, gt=eq=lt=0, shift registers=0, counter=0.
- cmp_reset = reset OR (state==CLEAR), so the comparator clears whenever this block resets.
- IDLE:
  - start=1 at an edge loads a_in/b_in into shift regs a_sh/b_sh and moves to CLEAR.
  - start=0 stays in IDLE.
- CLEAR (1 cycle):
  - cmp_reset=1, bit_valid=0, a_bit=b_bit=0.
  - At the edge: counter=WIDTH-1; go to SHIFT.
- SHIFT (exactly WIDTH cycles):
  - a_bit=a_sh[WIDTH-1], b_bit=b_sh[WIDTH-1], bit_valid=1.
  - Each edge shifts a_sh/b_sh left by 1 (zero fill) and decrements the counter.
  - The edge with counter==0 moves to CAPTURE.
- CAPTURE (1 cycle):
  - bit_valid=0, a_bit=b_bit=0; the comparator outputs are final.
  - At the edge: gt<=g_in, eq<=e_in, lt<=l_in, done<=1, go to IDLE.
- done is registered: high for the single cycle after CAPTURE, then 0.
- gt/eq/lt hold until the next CAPTURE or reset.
- Latency: the accept edge is edge 0; done is high in the cycle after edge WIDTH+2.
- Throughput: one comparison per WIDTH+3 cycles.
- Outside SHIFT, a_bit=b_bit=0 (equal pair), so a comparator that is not reset keeps its state.
- Boundary conditions:
  - start while ready=0: ignored, no queuing, operands not sampled.
  - start in the done cycle: accepted, since state is IDLE; done still pulses; the old result stays held until the new CAPTURE.
  - reset in any state, including mid-SHIFT: abort the operation, apply the reset values next cycle, no done pulse; the comparator is cleared via cmp_reset.
  - reset and start together: reset wins; start is not accepted.
  - WIDTH=1: SHIFT lasts 1 cycle.
  - Counter width is $clog2(WIDTH+1); counter never wraps.
  - g_in/e_in/l_in not one-hot at capture: values are stored verbatim; no correction.

Decomposition:
- Shared package holds the state enum (IDLE=2'd0, CLEAR=2'd1, SHIFT=2'd2, CAPTURE=2'd3).
- No sub-module; the two shift registers and the counter are inline.
- The bench instantiates this block with the serial comparator as the DUT pair.

Test Plan:
1. WIDTH=8, a_in=8'hA5, b_in=8'hA4, start pulse -> a_bit stream 1,0,1,0,0,1,0,1; b_bit stream 1,0,1,0,0,1,0,0; bit_valid high 8 cycles; done in the cycle after edge 10; gt=1 eq=0 lt=0.
2. a_in=8'h3C, b_in=8'h3C -> eq=1, gt=lt=0; cmp_reset high exactly 1 cycle before bit_valid.
3. a_in=8'h00, b_in=8'hFF -> lt=1 after the first bit; held result lt=1 at done.
4. Back-to-back: assert start with 8'h01/8'h02 in the done cycle of scenario 1 -> accepted; gt=1 persists until the second done; then lt=1.
5. start re-asserted mid-SHIFT with different operands -> ignored; the original bit stream and result are unchanged.
6. reset asserted on the 4th SHIFT cycle -> next cycle ready=1, bit_valid=0, done=0, gt=eq=lt=0; cmp_reset=1 while reset is high; a new comparison afterwards gives the correct result.
